// File: rtl/config_loader.sv
// config_loader: power-on configuration fetcher.
// Holds the system in reset and takes over the SRAM bus while it reads
// NUM_BYTES consecutive configuration bytes starting at BASE_ADDR. It then
// releases the bus and the reset. A reload request in RUN re-runs the fetch
// under reset, without the settle period.
module config_loader #(
  parameter int                      ADDR_W        = 21,
  parameter logic [ADDR_W-1:0]       BASE_ADDR     = 21'h008FD5,
  parameter int                      NUM_BYTES     = 4,
  parameter int                      SETTLE_CYCLES = 15,
  parameter int                      WAIT_CYCLES   = 2,
  parameter int                      RESET_HOLD    = 16,
  parameter logic [NUM_BYTES*8-1:0]  DEFAULT_CFG   = {NUM_BYTES*8{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reload,
  input  logic [ADDR_W-1:0]        sram_addr_in,
  input  logic                     sram_we_n_in,
  output logic [ADDR_W-1:0]        sram_addr_out,
  output logic                     sram_we_n_out,
  input  logic [7:0]               din,
  output logic                     pwon_reset,
  output logic                     busy,
  output logic                     cfg_valid,
  output logic [NUM_BYTES*8-1:0]   cfg_out,
  output logic                     vga_on,
  output logic                     scanlines_on
);

  // One cycle counter serves all three timed phases, so size it for the longest.
  localparam int CYC_MAX_A = (SETTLE_CYCLES - 1 > WAIT_CYCLES) ? SETTLE_CYCLES - 1 : WAIT_CYCLES;
  localparam int CYC_MAX   = (CYC_MAX_A > RESET_HOLD - 1) ? CYC_MAX_A : RESET_HOLD - 1;
  localparam int CYC_W     = (CYC_MAX < 1) ? 1 : $clog2(CYC_MAX + 1);
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WAIT_CYCLES);
  localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(RESET_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CYC_W-1:0]          r_cyc;
  logic [IDX_W-1:0]          r_idx;
  logic [NUM_BYTES*8-1:0]    r_cfg;

  logic                      w_in_reset;
  logic [ADDR_W-1:0]         w_idx_ext;
  logic [ADDR_W-1:0]         w_fetch_addr;

  // Sequencer: settle, fetch each byte at the end of its window, hold, run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SETTLE;
      r_cyc   <= '0;
      r_idx   <= '0;
      r_cfg   <= DEFAULT_CFG;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cyc == SETTLE_LAST) begin
            r_state <= ST_FETCH;
            r_cyc   <= '0;
            r_idx   <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        ST_FETCH: begin
          if (r_cyc == WINDOW_LAST) begin
            // din is sampled only on the edge that closes the window.
            for (int i = 0; i < NUM_BYTES; i++) begin
              if (r_idx == IDX_W'(i)) begin
                r_cfg[i*8 +: 8] <= din;
              end
            end
            r_cyc <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_HOLD;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cyc == HOLD_LAST) begin
            r_state <= ST_RUN;
            r_cyc   <= '0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        ST_RUN: begin
          // Reload skips settling: the SRAM is already powered and stable.
          if (reload) begin
            r_state <= ST_FETCH;
            r_cyc   <= '0;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= ST_SETTLE;
          r_cyc   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Status decodes of the registered state.
  assign w_in_reset = (r_state != ST_RUN);
  assign pwon_reset = w_in_reset;
  assign busy       = w_in_reset;
  assign cfg_valid  = (r_state == ST_RUN);

  // Bus mux: own the SRAM (read-only) while the system is held in reset.
  // The fetch address wraps modulo 2^ADDR_W.
  assign w_idx_ext     = ADDR_W'(r_idx);
  assign w_fetch_addr  = BASE_ADDR + w_idx_ext;
  assign sram_addr_out = w_in_reset ? w_fetch_addr : sram_addr_in;
  assign sram_we_n_out = w_in_reset ? 1'b1 : sram_we_n_in;

  assign cfg_out      = r_cfg;
  assign vga_on       = r_cfg[0];
  assign scanlines_on = r_cfg[1];

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed bench for config_loader.
// Instance a uses the default parameters. Instance b uses WAIT_CYCLES=0 and
// NUM_BYTES=1. Instance c uses a BASE_ADDR near the top of the address space,
// to exercise address wrap.
module tb_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        reload_a = 1'b0, reload_b = 1'b0, reload_c = 1'b0;
  logic [20:0] addr_in = 21'h012345;
  logic        we_n_in = 1'b0;
  logic [7:0]  mem0 = 8'h03;

  logic [20:0] addr_a, addr_b, addr_c;
  logic        we_a, we_b, we_c;
  logic [7:0]  din_a, din_b, din_c;
  logic        pwon_a, pwon_b, pwon_c;
  logic        busy_a, busy_b, busy_c;
  logic        valid_a, valid_b, valid_c;
  logic [31:0] cfg_a, cfg_c;
  logic [7:0]  cfg_b;
  logic        vga_a, vga_b, vga_c;
  logic        scan_a, scan_b, scan_c;

  // Small SRAM model: returns the configuration image for the addresses used here.
  function automatic logic [7:0] mem_byte(input logic [20:0] a, input logic [7:0] b0);
    case (a)
      21'h008FD5: return b0;
      21'h008FD6: return 8'hA5;
      21'h008FD7: return 8'h5A;
      21'h008FD8: return 8'hFF;
      21'h1FFFFE: return 8'h11;
      21'h1FFFFF: return 8'h22;
      21'h000000: return 8'h33;
      21'h000001: return 8'h44;
      default:    return 8'hEE;
    endcase
  endfunction

  always_comb din_a = mem_byte(addr_a, mem0);
  always_comb din_b = 8'h02;
  always_comb din_c = mem_byte(addr_c, mem0);

  config_loader dut_a (
    .clk(clk), .rst(rst_a), .reload(reload_a),
    .sram_addr_in(addr_in), .sram_we_n_in(we_n_in),
    .sram_addr_out(addr_a), .sram_we_n_out(we_a), .din(din_a),
    .pwon_reset(pwon_a), .busy(busy_a), .cfg_valid(valid_a),
    .cfg_out(cfg_a), .vga_on(vga_a), .scanlines_on(scan_a)
  );

  config_loader #(.WAIT_CYCLES(0), .NUM_BYTES(1)) dut_b (
    .clk(clk), .rst(rst_b), .reload(reload_b),
    .sram_addr_in(addr_in), .sram_we_n_in(we_n_in),
    .sram_addr_out(addr_b), .sram_we_n_out(we_b), .din(din_b),
    .pwon_reset(pwon_b), .busy(busy_b), .cfg_valid(valid_b),
    .cfg_out(cfg_b), .vga_on(vga_b), .scanlines_on(scan_b)
  );

  config_loader #(.BASE_ADDR(21'h1FFFFE)) dut_c (
    .clk(clk), .rst(rst_c), .reload(reload_c),
    .sram_addr_in(addr_in), .sram_we_n_in(we_n_in),
    .sram_addr_out(addr_c), .sram_we_n_out(we_c), .din(din_c),
    .pwon_reset(pwon_c), .busy(busy_c), .cfg_valid(valid_c),
    .cfg_out(cfg_c), .vga_on(vga_c), .scanlines_on(scan_c)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(); step();
    n_vec++; if (pwon_a !== 1'b1) begin n_err++; $display("FAIL reset_pwon got %b want 1", pwon_a); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", busy_a); end
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_a); end
    n_vec++; if (we_a !== 1'b1) begin n_err++; $display("FAIL reset_we_n got %b want 1", we_a); end
    n_vec++; if (addr_a !== 21'h008FD5) begin n_err++; $display("FAIL reset_addr got %h want 008fd5", addr_a); end
    n_vec++; if (cfg_a !== 32'h0) begin n_err++; $display("FAIL reset_cfg got %h want 00000000", cfg_a); end
    n_vec++; if (cfg_b !== 8'h0) begin n_err++; $display("FAIL reset_cfg_b got %h want 00", cfg_b); end
  endtask

  // Release rst_a and check the whole default boot sequence up to cycle 46.
  // With pulse_reload set, reload is driven high during SETTLE and must be ignored.
  task automatic test_boot_a(input bit pulse_reload);
    logic        exp_pwon;
    logic [20:0] exp_addr;
    rst_a = 1'b0;
    for (int k = 0; k <= 46; k++) begin
      if (k > 0) step();
      reload_a = pulse_reload && (k >= 5) && (k < 10);
      exp_pwon = (k < 43);
      n_vec++; if (pwon_a !== exp_pwon) begin n_err++; $display("FAIL boot_pwon cyc %0d got %b want %b", k, pwon_a, exp_pwon); end
      n_vec++; if (busy_a !== exp_pwon) begin n_err++; $display("FAIL boot_busy cyc %0d got %b want %b", k, busy_a, exp_pwon); end
      n_vec++; if (valid_a !== !exp_pwon) begin n_err++; $display("FAIL boot_valid cyc %0d got %b want %b", k, valid_a, !exp_pwon); end
      if (k < 43) begin
        n_vec++; if (we_a !== 1'b1) begin n_err++; $display("FAIL boot_we_n cyc %0d got %b want 1", k, we_a); end
        n_vec++; if (addr_a === 21'h012345) begin n_err++; $display("FAIL boot_addr_leak cyc %0d got %h want not 012345", k, addr_a); end
      end else begin
        n_vec++; if (we_a !== 1'b0) begin n_err++; $display("FAIL pass_we_n cyc %0d got %b want 0", k, we_a); end
        n_vec++; if (addr_a !== 21'h012345) begin n_err++; $display("FAIL pass_addr cyc %0d got %h want 012345", k, addr_a); end
      end
      if (k < 27) begin
        exp_addr = (k < 15) ? 21'h008FD5 : 21'(32'h8FD5 + (k - 15) / 3);
        n_vec++; if (addr_a !== exp_addr) begin n_err++; $display("FAIL boot_addr cyc %0d got %h want %h", k, addr_a, exp_addr); end
      end
    end
    reload_a = 1'b0;
    n_vec++; if (cfg_a !== 32'hFF5AA503) begin n_err++; $display("FAIL boot_cfg got %h want ff5aa503", cfg_a); end
    n_vec++; if (vga_a !== 1'b1) begin n_err++; $display("FAIL boot_vga got %b want 1", vga_a); end
    n_vec++; if (scan_a !== 1'b1) begin n_err++; $display("FAIL boot_scan got %b want 1", scan_a); end
  endtask

  // Reload from RUN with byte 0 changed in SRAM.
  task automatic test_reload();
    logic [20:0] exp_addr;
    mem0 = 8'h00;
    reload_a = 1'b1;
    n_vec++; if (pwon_a !== 1'b0) begin n_err++; $display("FAIL reload_pre_pwon got %b want 0", pwon_a); end
    for (int j = 1; j <= 30; j++) begin
      step();
      reload_a = 1'b0;
      n_vec++; if (pwon_a !== (j <= 28)) begin n_err++; $display("FAIL reload_pwon j %0d got %b want %b", j, pwon_a, (j <= 28)); end
      n_vec++; if (valid_a !== (j > 28)) begin n_err++; $display("FAIL reload_valid j %0d got %b want %b", j, valid_a, (j > 28)); end
      if (j <= 12) begin
        exp_addr = 21'(32'h8FD5 + (j - 1) / 3);
        n_vec++; if (addr_a !== exp_addr) begin n_err++; $display("FAIL reload_addr j %0d got %h want %h", j, addr_a, exp_addr); end
      end
      if (j == 3) begin
        n_vec++; if (vga_a !== 1'b1) begin n_err++; $display("FAIL reload_vga_old got %b want 1", vga_a); end
        n_vec++; if (cfg_a !== 32'hFF5AA503) begin n_err++; $display("FAIL reload_cfg_old got %h want ff5aa503", cfg_a); end
      end
      if (j == 4) begin
        n_vec++; if (vga_a !== 1'b0) begin n_err++; $display("FAIL reload_vga_new got %b want 0", vga_a); end
      end
    end
    n_vec++; if (cfg_a !== 32'hFF5AA500) begin n_err++; $display("FAIL reload_cfg got %h want ff5aa500", cfg_a); end
    n_vec++; if (scan_a !== 1'b0) begin n_err++; $display("FAIL reload_scan got %b want 0", scan_a); end
  endtask

  // Assert rst during the byte-2 window, then check full recovery.
  task automatic test_midfetch_reset();
    mem0 = 8'h03;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int k = 1; k <= 21; k++) step();
    n_vec++; if (cfg_a !== 32'h0000A503) begin n_err++; $display("FAIL partial_cfg got %h want 0000a503", cfg_a); end
    rst_a = 1'b1;
    #1;
    n_vec++; if (cfg_a !== 32'h0) begin n_err++; $display("FAIL midrst_cfg got %h want 00000000", cfg_a); end
    n_vec++; if (pwon_a !== 1'b1) begin n_err++; $display("FAIL midrst_pwon got %b want 1", pwon_a); end
    n_vec++; if (addr_a !== 21'h008FD5) begin n_err++; $display("FAIL midrst_addr got %h want 008fd5", addr_a); end
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", valid_a); end
    @(negedge clk);
    test_boot_a(1'b1);
  endtask

  // WAIT_CYCLES=0, NUM_BYTES=1: one 1-cycle window at 15, RUN at 32.
  task automatic test_short();
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) step();
      n_vec++; if (pwon_b !== (k < 32)) begin n_err++; $display("FAIL short_pwon cyc %0d got %b want %b", k, pwon_b, (k < 32)); end
      if (k == 15) begin
        n_vec++; if (cfg_b !== 8'h00) begin n_err++; $display("FAIL short_cfg15 got %h want 00", cfg_b); end
      end
      if (k == 16) begin
        n_vec++; if (cfg_b !== 8'h02) begin n_err++; $display("FAIL short_cfg16 got %h want 02", cfg_b); end
      end
    end
    n_vec++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL short_valid got %b want 1", valid_b); end
    n_vec++; if (vga_b !== 1'b0) begin n_err++; $display("FAIL short_vga got %b want 0", vga_b); end
    n_vec++; if (scan_b !== 1'b1) begin n_err++; $display("FAIL short_scan got %b want 1", scan_b); end
  endtask

  // BASE_ADDR near the top: fetch addresses wrap to zero.
  task automatic test_wrap();
    logic [20:0] base;
    logic [20:0] exp_addr;
    base = 21'h1FFFFE;
    @(negedge clk);
    rst_c = 1'b0;
    for (int k = 0; k <= 43; k++) begin
      if (k > 0) step();
      if (k >= 15 && k < 27) begin
        exp_addr = base + 21'((k - 15) / 3);
        n_vec++; if (addr_c !== exp_addr) begin n_err++; $display("FAIL wrap_addr cyc %0d got %h want %h", k, addr_c, exp_addr); end
      end
    end
    n_vec++; if (pwon_c !== 1'b0) begin n_err++; $display("FAIL wrap_pwon got %b want 0", pwon_c); end
    n_vec++; if (cfg_c !== 32'h44332211) begin n_err++; $display("FAIL wrap_cfg got %h want 44332211", cfg_c); end
  endtask

  initial begin
    test_reset();
    test_boot_a(1'b0);
    test_reload();
    test_midfetch_reset();
    test_short();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Power-on configuration fetcher. Holds the system in reset, takes over the SRAM bus, reads NUM_BYTES consecutive configuration bytes from BASE_ADDR, latches them, then releases the bus and the reset.
- Sits between core SRAM master and SRAM pins in the top-level wrapper; drives video-mode and other boot options.
- Supports a runtime reload request that re-runs the fetch under reset.

Parameters:
- ADDR_W, 21, SRAM address width.
- BASE_ADDR, 21'h008FD5, address of config byte 0.
- NUM_BYTES, 4, number of config bytes fetched (1..16).
- SETTLE_CYCLES, 15, cycles after reset release before first fetch (SRAM/power settle, ≥1).
- WAIT_CYCLES, 2, extra cycles each address is held before din is sampled (≥0).
- RESET_HOLD, 16, cycles pwon_reset stays high after last byte sampled (≥1).
- DEFAULT_CFG, {NUM_BYTES*8{1'b0}}, cfg_out value while reset is asserted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- reload  in  1  pulse in RUN: re-fetch configuration
- sram_addr_in  in  ADDR_W  address from core master
- sram_we_n_in  in  1  write enable (active low) from core master
- sram_addr_out  out  ADDR_W  address to SRAM
- sram_we_n_out  out  1  write enable to SRAM
- din  in  8  SRAM read data
- pwon_reset  out  1  system reset, high while not in RUN
- busy  out  1  high in SETTLE/FETCH/HOLD
- cfg_valid  out  1  high in RUN once a full fetch completed
- cfg_out  out  NUM_BYTES*8  byte i at bits [8i+7:8i]
- vga_on  out  1  cfg_out[0]
- scanlines_on  out  1  cfg_out[1]

Behaviour:
- States: SETTLE, FETCH, HOLD, RUN. Counters: cyc (cycle counter), idx (byte index).
- rst high (async): state=SETTLE, cyc=0, idx=0, cfg_out=DEFAULT_CFG, pwon_reset=1, busy=1, cfg_valid=0, sram_we_n_out=1, sram_addr_out=BASE_ADDR.
- pwon_reset = busy = (state != RUN). cfg_valid = (state == RUN). These are combinational decodes of the registered state.
- Bus mux is combinational:
  - pwon_reset=1: sram_addr_out = BASE_ADDR + idx, truncated mod 2^ADDR_W (wrap allowed); sram_we_n_out=1.
  - pwon_reset=0: pass sram_addr_in and sram_we_n_in through.
- SETTLE: lasts SETTLE_CYCLES cycles, then FETCH with idx=0, cyc=0.
- FETCH: each byte window is WAIT_CYCLES+1 cycles with a stable address. On the edge ending the window, cfg_out[idx] <= din. Then either idx+1 (stay in FETCH), or go to HOLD after idx=NUM_BYTES-1.
- HOLD: RESET_HOLD cycles, then RUN.
- Timing with defaults, cycle k = after k edges post-rst release:
  - cycles 0–14: SETTLE.
  - byte i window: cycles 15+3i..17+3i.
  - cycles 27–42: HOLD.
  - RUN from cycle 43: pwon_reset falls, cfg_valid rises.
- RUN: reload=1 at an edge sends state to FETCH (idx=0, cyc=0, no SETTLE). pwon_reset rises the following cycle.
- During a reload, cfg_out keeps old bytes until each is overwritten in turn.
- reload outside RUN is ignored. reload held high re-triggers on every entry to RUN.
- rst asserted mid-operation: immediate async return to reset values, including cfg_out=DEFAULT_CFG. A partial fetch is discarded.
- No write ever issued by this block. din is only sampled at window-end edges.

Test Plan:
- Defaults, SRAM model with 0x8FD5=0x03, 0x8FD6=0xA5, 0x8FD7=0x5A, 0x8FD8=0xFF; release rst.
  -> pwon_reset high cycles 0–42, low at 43.
  -> cfg_out=32'hFF5AA503; vga_on=1, scanlines_on=1.
  -> sram_addr_out sequence 8FD5/8FD6/8FD7/8FD8, each held 3 cycles.
- During boot, drive sram_we_n_in=0 and sram_addr_in=0x12345.
  -> sram_we_n_out=1 and sram_addr_out != 0x12345 until cycle 43.
  -> then passthrough exactly.
- WAIT_CYCLES=0, NUM_BYTES=1, din=0x02.
  -> single 1-cycle window at cycle 15; RUN at cycle 32.
  -> vga_on=0, scanlines_on=1.
- BASE_ADDR=21'h1FFFFE, NUM_BYTES=4.
  -> addresses 1FFFFE, 1FFFFF, 000000, 000001.
- In RUN, pulse reload with SRAM byte0 changed to 0x00.
  -> pwon_reset high next cycle for 4×3+16=28 cycles.
  -> vga_on drops when byte0 is sampled; cfg_valid returns at the end.
- Assert rst at the byte-2 window of the first fetch.
  -> cfg_out=0 immediately, state=SETTLE.
  -> after release, the full 43-cycle sequence repeats and correct values load.
